// File: rtl/pe_driver.sv
// Command/operand sequencer for a single weight- or input-stationary MAC PE.
// Preloads the stationary value, streams operands under a 2-credit budget and buffers PE results.
module pe_driver #(
   parameter int DATA_WIDTH  = 16,
   parameter int ACCUM_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_mode,
   input  logic [DATA_WIDTH-1:0]  cmd_weight,
   input  logic [7:0]             cmd_len,
   input  logic                   op_valid,
   output logic                   op_ready,
   input  logic [DATA_WIDTH-1:0]  op_a,
   input  logic [ACCUM_WIDTH-1:0] op_psum,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [ACCUM_WIDTH-1:0] res_data,
   output logic                   res_last,
   output logic [1:0]             dataflow_sel,
   output logic                   preload_en,
   output logic [DATA_WIDTH-1:0]  preload_data,
   output logic [DATA_WIDTH-1:0]  pe_input_0,
   output logic [ACCUM_WIDTH-1:0] pe_input_1,
   output logic [DATA_WIDTH-1:0]  pe_input_2,
   input  logic [ACCUM_WIDTH-1:0] pe_output_1,
   output logic                   busy,
   output logic                   err,
   output logic [1:0]             fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, PRELOAD = 2'd1, STREAM = 2'd2, DRAIN = 2'd3} state_t;

   state_t                 state, state_next;
   logic [DATA_WIDTH-1:0]  weight_q;
   logic [7:0]             len_q;
   logic [7:0]             op_cnt;
   logic                   inflight;
   logic                   inflight_last;
   logic [ACCUM_WIDTH-1:0] fifo_data [2];
   logic                   fifo_last [2];
   logic                   wr_ptr, rd_ptr;
   logic [1:0]             fifo_count;

   logic cmd_fire, cmd_legal, op_fire, op_is_last, push, pop;

   // Every channel transfers on a cycle where valid and ready are both high at the
   // rising edge; valid never depends on ready, and ready never depends on valid.
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign cmd_legal  = !cmd_mode[1];
   assign op_fire    = op_valid && op_ready;
   assign op_is_last = op_fire && ((op_cnt + 8'd1) == len_q);
   assign push       = inflight;
   assign pop        = res_valid && res_ready;

   assign cmd_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   assign fsm_state    = state;
   assign preload_en   = (state == PRELOAD);
   assign preload_data = preload_en ? weight_q : '0;
   // Credits count both buffered results and the one still inside the PE.
   assign op_ready     = (state == STREAM) && ((fifo_count + {1'b0, inflight}) < 2'd2);
   assign pe_input_0   = '0;
   assign pe_input_1   = op_fire ? op_psum : '0;
   assign pe_input_2   = op_fire ? op_a : '0;
   assign res_valid    = (fifo_count != 2'd0);
   assign res_data     = fifo_data[rd_ptr];
   assign res_last     = fifo_last[rd_ptr];

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cmd_fire && cmd_legal) state_next = PRELOAD;
         PRELOAD: state_next = (len_q != 8'd0) ? STREAM : IDLE;
         STREAM:  if (op_is_last) state_next = DRAIN;
         DRAIN:   if (!inflight && (fifo_count == 2'd0)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dataflow_sel  <= 2'b00;
         weight_q      <= '0;
         len_q         <= '0;
         op_cnt        <= '0;
         err           <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         err           <= cmd_fire && !cmd_legal;
         inflight      <= op_fire;
         inflight_last <= op_is_last;
         if (cmd_fire && cmd_legal) begin
            dataflow_sel <= cmd_mode;
            weight_q     <= cmd_weight;
            len_q        <= cmd_len;
            op_cnt       <= '0;
         end else if (op_fire) begin
            op_cnt <= op_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= pe_output_1;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule
